// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the uart_rx slice: status bit positions, register
// addresses, FSM state encodings and the status-word packing helper.
package uart_rx_pkg;

    localparam int ST_RXF   = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_FE    = 2;
    localparam int ST_FFULL = 3;
    localparam int ST_IRQEN = 7;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    function automatic logic [7:0] pack_status(
        input logic rxf,
        input logic ovr,
        input logic fe,
        input logic ffull,
        input logic irq_en
    );
        logic [7:0] s;
        s           = '0;
        s[ST_RXF]   = rxf;
        s[ST_OVR]   = ovr;
        s[ST_FE]    = fe;
        s[ST_FFULL] = ffull;
        s[ST_IRQEN] = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// CPU bus window and serial line of the receiver; master is the CPU/board side,
// slave is the uart_rx block.
interface uart_rx_if;
    logic       ADDR;
    logic       R;
    logic       W;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       RXD;
    logic       IRQ;

    modport master (
        output ADDR, R, W, DATA_IN, RXD,
        input  DATA_OUT, IRQ
    );

    modport slave (
        input  ADDR, R, W, DATA_IN, RXD,
        output DATA_OUT, IRQ
    );
endinterface

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Small synchronous FIFO with first-word-fall-through head, full/empty flags and
// simultaneous push/pop (a push while full succeeds if a pop happens that cycle).
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Head must be visible combinationally on the bus, so the array is read asynchronously.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver behind a two-register CPU window (data, status/control).
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     CLK,
    input  logic     RESET,
    uart_rx_if.slave bus
);
    localparam int              CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

    logic             rxd_meta_reg, rxd_sync_reg, rxd_hist_reg;
    logic             r_prev_reg, w_prev_reg;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             armed_reg, armed_next;
    logic             load_reg, load_next;
    logic             stop_bit_reg, stop_bit_next;
    logic             ovr_reg, ovr_next;
    logic             fe_reg, fe_next;
    logic             irq_en_reg, irq_en_next;

    logic             start_edge, cnt_zero;
    logic             data_read, ctrl_write;
    logic             ovr_set, fe_set;
    logic             rx_full, ffull;
    logic [7:0]       data_view;
    logic             unused_data_bits;

    assign start_edge = rxd_hist_reg && !rxd_sync_reg;
    assign cnt_zero   = (cnt_reg == '0);
    assign data_read  = r_prev_reg && !bus.R && (bus.ADDR == ADDR_DATA);
    assign ctrl_write = w_prev_reg && !bus.W && (bus.ADDR == ADDR_CTRL);
    assign fe_set     = load_reg && !stop_bit_reg;
    assign unused_data_bits = ^{bus.DATA_IN[6:3], bus.DATA_IN[0]};

    // Frame FSM; armed_reg blocks a new start until the line has been seen idle after a framing error.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        armed_next    = armed_reg;
        load_next     = 1'b0;
        stop_bit_next = stop_bit_reg;
        case (state_reg)
            IDLE: begin
                if (rxd_sync_reg) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && start_edge) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (rxd_sync_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next   = DATA;
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    shift_next = {rxd_sync_reg, shift_reg[7:1]};
                    cnt_next   = FULL_LOAD;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    stop_bit_next = rxd_sync_reg;
                    load_next     = 1'b1;
                    state_next    = IDLE;
                    if (!rxd_sync_reg) begin
                        armed_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_pop  = data_read && !fifo_empty;
    assign fifo_push = load_reg && (!fifo_full || fifo_pop);
    assign ovr_set   = load_reg && !fifo_push;
    assign rx_full   = !fifo_empty;
    assign ffull     = fifo_full;

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (fifo_push),
        .din   (shift_reg),
        .pop   (fifo_pop),
        .head  (data_view),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    logic [7:0] data_reg;
    logic       rx_full_reg;
    logic       load_ok;

    // A read in the same cycle as a load frees the register, so the new byte wins without overrun.
    assign load_ok   = load_reg && (!rx_full_reg || data_read);
    assign ovr_set   = load_reg && !load_ok;
    assign rx_full   = rx_full_reg;
    assign ffull     = 1'b0;
    assign data_view = data_reg;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            data_reg    <= 8'h00;
            rx_full_reg <= 1'b0;
        end else if (load_ok) begin
            data_reg    <= shift_reg;
            rx_full_reg <= 1'b1;
        end else if (data_read) begin
            rx_full_reg <= 1'b0;
        end
    end
`endif

    // Sets are applied after clears so a flag set and cleared in one cycle ends set.
    always_comb begin
        ovr_next    = ovr_reg;
        fe_next     = fe_reg;
        irq_en_next = irq_en_reg;
        if (ctrl_write) begin
            irq_en_next = bus.DATA_IN[ST_IRQEN];
            if (bus.DATA_IN[ST_OVR]) ovr_next = 1'b0;
            if (bus.DATA_IN[ST_FE])  fe_next  = 1'b0;
        end
        if (ovr_set) ovr_next = 1'b1;
        if (fe_set)  fe_next  = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
            rxd_hist_reg <= 1'b1;
            r_prev_reg   <= 1'b1;
            w_prev_reg   <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            armed_reg    <= 1'b1;
            load_reg     <= 1'b0;
            stop_bit_reg <= 1'b1;
            ovr_reg      <= 1'b0;
            fe_reg       <= 1'b0;
            irq_en_reg   <= 1'b0;
        end else begin
            rxd_meta_reg <= bus.RXD;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_hist_reg <= rxd_sync_reg;
            r_prev_reg   <= bus.R;
            w_prev_reg   <= bus.W;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            armed_reg    <= armed_next;
            load_reg     <= load_next;
            stop_bit_reg <= stop_bit_next;
            ovr_reg      <= ovr_next;
            fe_reg       <= fe_next;
            irq_en_reg   <= irq_en_next;
        end
    end

    assign bus.DATA_OUT = (bus.ADDR == ADDR_CTRL)
                        ? pack_status(rx_full, ovr_reg, fe_reg, ffull, irq_en_reg)
                        : data_view;
    assign bus.IRQ      = !(irq_en_reg && (rx_full || ovr_reg || fe_reg));

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: serial frames and CPU accesses are driven from a
// stimulus process; a monitor compares every register read against a queued expectation.
module tb_uart_rx;
    localparam int BAUD = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP       = 4;
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam int CAP       = 1;
    localparam bit FIFO_MODE = 1'b0;
`endif

    typedef struct packed {
        logic       a;
        logic [7:0] v;
    } exp_t;

    logic CLK;
    logic RESET;
    uart_rx_if bus ();

    uart_rx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Behavioural model: received bytes waiting for the CPU, last loaded byte, sticky flags.
    logic [7:0] ref_q[$];
    logic [7:0] last_data;
    logic       m_ovr, m_fe, m_irq_en;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        ref_q.delete();
        last_data = 8'h00;
        m_ovr     = 1'b0;
        m_fe      = 1'b0;
        m_irq_en  = 1'b0;
    endfunction

    function automatic void m_rx(input logic [7:0] b, input logic stop);
        if (!stop) m_fe = 1'b1;
        if (ref_q.size() < CAP) begin
            ref_q.push_back(b);
            last_data = b;
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = (ref_q.size() != 0);
        s[1] = m_ovr;
        s[2] = m_fe;
        s[3] = FIFO_MODE && (ref_q.size() == CAP);
        s[7] = m_irq_en;
        return s;
    endfunction

    function automatic logic m_irq();
        return !(m_irq_en && ((ref_q.size() != 0) || m_ovr || m_fe));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name);
        logic e;
        e = m_irq();
        checks++;
        if (bus.IRQ !== e) begin
            errors++;
            $display("FAIL %s: IRQ got %b expected %b", name, bus.IRQ, e);
        end
    endtask

    task automatic cpu_read(input logic a);
        logic [7:0] e;
        if (a) begin
            e = m_status();
        end else begin
            e = FIFO_MODE ? ((ref_q.size() != 0) ? ref_q[0] : 8'h00) : last_data;
            if (ref_q.size() != 0) void'(ref_q.pop_front());
        end
        exp_q.push_back('{a: a, v: e});
        bus.ADDR = a;
        bus.R    = 1'b0;
        tick(2);
        bus.R    = 1'b1;
        tick(1);
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] v);
        if (a) begin
            m_irq_en = v[7];
            if (v[1]) m_ovr = 1'b0;
            if (v[2]) m_fe  = 1'b0;
        end
        $display("wr addr=%0d data=0x%02h", a, v);
        bus.ADDR    = a;
        bus.DATA_IN = v;
        bus.W       = 1'b0;
        tick(2);
        bus.W       = 1'b1;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_bits);
        bus.RXD = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            bus.RXD = b[i];
            tick(BAUD);
        end
        bus.RXD = stop;
        tick(BAUD * (1 + hold_bits));
        bus.RXD = 1'b1;
        tick(BAUD);
        m_rx(b, stop);
        $display("rx frame 0x%02h stop=%0d", b, stop);
    endtask

    // Monitor: every falling edge of R is a CPU read; compare DATA_OUT before the side effect.
    initial begin
        logic r_last;
        exp_t e;
        r_last = 1'b1;
        forever begin
            @(negedge CLK);
            if (RESET && r_last && !bus.R) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%02h expected none", bus.DATA_OUT);
                end else begin
                    e = exp_q.pop_front();
                    check8(e.a ? "status_rd" : "data_rd", bus.DATA_OUT, e.v);
                    $display("rd addr=%0d data=0x%02h exp=0x%02h", e.a, bus.DATA_OUT, e.v);
                end
            end
            r_last = bus.R;
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop;
        int         nrd;

        bus.ADDR    = 1'b0;
        bus.R       = 1'b1;
        bus.W       = 1'b1;
        bus.DATA_IN = 8'h00;
        bus.RXD     = 1'b1;
        RESET       = 1'b0;
        m_reset();
        tick(3);
        check_irq("irq_in_reset");
        RESET = 1'b1;
        tick(2);

        cpu_read(1'b1);
        cpu_read(1'b0);

        send_frame(8'hA5, 1'b1, 0);
        check_irq("irq_disabled");
        cpu_read(1'b1);
        cpu_read(1'b0);
        cpu_read(1'b1);

        cpu_write(1'b1, 8'h80);
        send_frame(8'h3C, 1'b1, 0);
        check_irq("irq_asserted");
        cpu_read(1'b0);
        check_irq("irq_after_read");

        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        cpu_read(1'b1);
        check_irq("irq_overrun");
        cpu_read(1'b0);
        cpu_write(1'b1, 8'h82);
        cpu_read(1'b1);
        cpu_read(1'b0);

        // Bad stop bit, then the line stays low for 20 bit times: no extra byte may appear.
        send_frame(8'h55, 1'b0, 20);
        cpu_read(1'b1);
        check_irq("irq_framing");
        cpu_read(1'b0);
        cpu_write(1'b1, 8'h84);
        cpu_read(1'b1);

        bus.RXD = 1'b0;
        tick(6);
        bus.RXD = 1'b1;
        tick(3 * BAUD);
        cpu_read(1'b1);
        check_irq("irq_glitch");
        send_frame(8'h69, 1'b1, 0);
        cpu_read(1'b0);

        // Reset in the middle of bit 4 with a byte pending and interrupts enabled.
        send_frame(8'h7E, 1'b1, 0);
        check_irq("irq_pending");
        b = 8'hC3;
        bus.RXD = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 4; i++) begin
            bus.RXD = b[i];
            tick(BAUD);
        end
        bus.RXD = b[4];
        tick(BAUD / 2);
        RESET = 1'b0;
        m_reset();
        bus.ADDR = 1'b0;
        tick(2);
        check_irq("irq_mid_reset");
        check8("data_out_mid_reset", bus.DATA_OUT, 8'h00);
        RESET   = 1'b1;
        bus.RXD = 1'b1;
        tick(12 * BAUD);
        cpu_read(1'b1);
        cpu_read(1'b0);

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 0);
        end
        cpu_read(1'b1);
        for (int i = 0; i < 4; i++) begin
            cpu_read(1'b0);
        end
        cpu_read(1'b1);
        cpu_write(1'b1, 8'h86);
        cpu_read(1'b1);

        for (int it = 0; it < 16; it++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, 0);
            check_irq("irq_rand");
            nrd = $urandom_range(0, 2);
            for (int k = 0; k < nrd; k++) begin
                cpu_read(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 2) == 0) begin
                cpu_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
            cpu_read(1'b1);
        end

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d unchecked expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
